// File: rtl/itf_req_sched_pkg.sv
// itf_pkg: shared state encoding, port counts and direction constants for the interface request scheduler
package itf_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, XFER = 2'd2} stateT;
  localparam int NUM_WRPORT_DEF = 4;
  localparam int NUM_RDPORT_DEF = 2;
  localparam int NUM_PORT = NUM_WRPORT_DEF + NUM_RDPORT_DEF;
  localparam int PW = $clog2(NUM_PORT);
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DRAM_ADDR_WIDTH_DEF = 32;
  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;
endpackage

// File: rtl/itf_req_sched_if.sv
// itf_req_sched_if: buffer request flags in, registered grant command out, transfer completion back
interface itf_req_sched_if import itf_pkg::*; #(
  parameter int NUM_WRPORT = NUM_WRPORT_DEF,
  parameter int NUM_RDPORT = NUM_RDPORT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DRAM_ADDR_WIDTH = DRAM_ADDR_WIDTH_DEF
) ();
  localparam int N = NUM_WRPORT + NUM_RDPORT;
  localparam int IW = $clog2(N);
  logic [N-1:0] Req_Urgent;
  logic [N*ADDR_WIDTH-1:0] Req_Num;
  logic [N*ADDR_WIDTH-1:0] Req_Addr;
  logic [N*DRAM_ADDR_WIDTH-1:0] Req_BaseAddr;
  logic Gnt_Vld;
  logic Gnt_Rdy;
  logic [IW-1:0] Gnt_Idx;
  logic Gnt_Rd;
  logic [ADDR_WIDTH-1:0] Gnt_Num;
  logic [DRAM_ADDR_WIDTH-1:0] Gnt_DramAddr;
  logic Xfer_Done;
  logic Busy;
  modport master (
    input Req_Urgent, Req_Num, Req_Addr, Req_BaseAddr, Gnt_Rdy, Xfer_Done,
    output Gnt_Vld, Gnt_Idx, Gnt_Rd, Gnt_Num, Gnt_DramAddr, Busy
  );
  modport slave (
    output Req_Urgent, Req_Num, Req_Addr, Req_BaseAddr, Gnt_Rdy, Xfer_Done,
    input Gnt_Vld, Gnt_Idx, Gnt_Rd, Gnt_Num, Gnt_DramAddr, Busy
  );
endinterface

// File: rtl/itf_req_sched_rr_pick.sv
// itf_rr_pick: round-robin search, first set request at index >= ptr, wrapping N-1 -> 0
module itf_rr_pick #(
  parameter int N = 6,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  localparam logic [IW:0] NV = (IW+1)'(N);
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  // rotate so ptr lands on bit 0, take lowest set bit, then rotate the offset back with explicit wrap
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= NV) ? IW'(sum - NV) : IW'(sum);
    found = |req;
  end
endmodule

// File: rtl/itf_req_sched.sv
// itf_req_sched: PAD-link request scheduler; optional per-port aging promotion under ITF_SCHED_AGING_EN
module itf_req_sched import itf_pkg::*; #(
  parameter int NUM_WRPORT = NUM_WRPORT_DEF,
  parameter int NUM_RDPORT = NUM_RDPORT_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DRAM_ADDR_WIDTH = DRAM_ADDR_WIDTH_DEF,
  parameter int AGE_LIMIT = 255
) (
  input logic clk,
  input logic rst_n,
  itf_req_sched_if.master bus
);
  localparam int N = NUM_WRPORT + NUM_RDPORT;
  localparam int IW = $clog2(N);
  localparam int AW = ADDR_WIDTH;
  localparam int DAW = DRAM_ADDR_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] FIRST_RD = IW'(NUM_WRPORT);
  stateT state, nextState;
  logic [IW-1:0] ptr, uIdx, nIdx, winIdx, gntIdx;
  logic [N-1:0] urgVec, normVec;
  logic uFound, nFound, anyReq, hs, gntRd;
  logic [AW-1:0] gntNum;
  logic [DAW-1:0] gntAddr;
  // a port has a normal request whenever it reports pending words
  always_comb for (int p = 0; p < N; p++) normVec[p] = bus.Req_Num[p*AW +: AW] != '0;
`ifdef ITF_SCHED_AGING_EN
  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
  logic [7:0] age [N];
  // ages count waiting cycles of ungranted ports with pending words, saturating; cleared when the port is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int p = 0; p < N; p++) age[p] <= '0;
    else for (int p = 0; p < N; p++)
      age[p] <= (hs && gntIdx == IW'(p)) ? '0 :
                (normVec[p] && !(state != IDLE && gntIdx == IW'(p)) && age[p] != AGE_MAX) ? age[p] + 8'd1 : age[p];
  // a port that has waited long enough competes alongside the urgent ones
  always_comb for (int p = 0; p < N; p++) urgVec[p] = bus.Req_Urgent[p] | (age[p] == AGE_MAX);
`else
  // without aging only the buffer EmptyFull flags make a port urgent
  always_comb urgVec = bus.Req_Urgent;
`endif
  itf_rr_pick #(.N(N), .IW(IW)) uPick (.req(urgVec), .ptr(ptr), .found(uFound), .idx(uIdx));
  itf_rr_pick #(.N(N), .IW(IW)) nPick (.req(normVec), .ptr(ptr), .found(nFound), .idx(nIdx));
  // port 0 urgent overrides everything, then the urgent round-robin, then the normal round-robin
  always_comb begin
    winIdx = bus.Req_Urgent[0] ? '0 : uFound ? uIdx : nIdx;
    anyReq = uFound | nFound;
    hs = (state == CMD) & bus.Gnt_Rdy;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // next state: offer a command, wait for acceptance, wait for burst completion
  always_comb
    nextState = (state == IDLE) ? (anyReq ? CMD : IDLE) :
                (state == CMD) ? (bus.Gnt_Rdy ? XFER : CMD) :
                (bus.Xfer_Done ? IDLE : XFER);
  // grant payload is captured only when leaving IDLE, so later request changes cannot disturb it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gntIdx <= '0;
      gntRd <= DIR_WR;
      gntNum <= '0;
      gntAddr <= '0;
      ptr <= '0;
    end else begin
      if (state == IDLE && anyReq) begin
        gntIdx <= winIdx;
        gntRd <= (winIdx >= FIRST_RD) ? DIR_RD : DIR_WR;
        gntNum <= bus.Req_Num[winIdx*AW +: AW];
        gntAddr <= bus.Req_BaseAddr[winIdx*DAW +: DAW] + DAW'(bus.Req_Addr[winIdx*AW +: AW]);
      end
      if (hs) ptr <= (gntIdx == LAST) ? '0 : gntIdx + 1'b1;
    end
  // outputs: valid only while offering the command, busy for the whole grant lifetime
  always_comb begin
    bus.Gnt_Vld = state == CMD;
    bus.Busy = state != IDLE;
    bus.Gnt_Idx = gntIdx;
    bus.Gnt_Rd = gntRd;
    bus.Gnt_Num = gntNum;
    bus.Gnt_DramAddr = gntAddr;
  end
endmodule

// File: tb/tb_itf_req_sched.sv
// tb_itf_req_sched: directed scenarios plus random traffic checked against a transaction-level scheduler model
module tb_itf_req_sched;
  import itf_pkg::*;
`ifdef ITF_SCHED_AGING_EN
  localparam int AL = 3;
`else
  localparam int AL = 255;
`endif
  localparam int N = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  itf_req_sched_if #(.NUM_WRPORT(4), .NUM_RDPORT(2), .ADDR_WIDTH(16), .DRAM_ADDR_WIDTH(32)) bus ();
  itf_req_sched #(.NUM_WRPORT(4), .NUM_RDPORT(2), .ADDR_WIDTH(16), .DRAM_ADDR_WIDTH(32), .AGE_LIMIT(AL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] getNum(input int p);
    return bus.Req_Num[p*16 +: 16];
  endfunction
  function automatic logic [15:0] getAddr(input int p);
    return bus.Req_Addr[p*16 +: 16];
  endfunction
  function automatic logic [31:0] getBase(input int p);
    return bus.Req_BaseAddr[p*32 +: 32];
  endfunction

  task automatic setPort(input int p, input logic [15:0] num, input logic [15:0] addr, input logic [31:0] base);
    bus.Req_Num[p*16 +: 16] = num;
    bus.Req_Addr[p*16 +: 16] = addr;
    bus.Req_BaseAddr[p*32 +: 32] = base;
  endtask

  task automatic clearReq();
    bus.Req_Urgent = '0;
    bus.Req_Num = '0;
    bus.Req_Addr = '0;
    bus.Req_BaseAddr = '0;
  endtask

  // model: a grant is either offered (pending), accepted (active) or absent
  bit mPend, mAct;
  int mPtr, eIdx, mW;
  logic [15:0] eNum;
  logic [31:0] eAddr;
  logic [N-1:0] mUrg;
  int age [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPend = 0;
      mAct = 0;
      mPtr = 0;
      eIdx = 0;
      for (int p = 0; p < N; p++) age[p] = 0;
    end else begin
      mUrg = bus.Req_Urgent;
`ifdef ITF_SCHED_AGING_EN
      for (int p = 0; p < N; p++) if (age[p] == AL) mUrg[p] = 1'b1;
      for (int p = 0; p < N; p++)
        if (mPend && bus.Gnt_Rdy && p == eIdx) age[p] = 0;
        else if (getNum(p) != 0 && !((mPend || mAct) && p == eIdx) && age[p] < AL) age[p]++;
`endif
      if (!mPend && !mAct) begin
        mW = -1;
        if (bus.Req_Urgent[0]) mW = 0;
        for (int i = 0; i < N; i++) if (mW < 0 && mUrg[(mPtr + i) % N]) mW = (mPtr + i) % N;
        for (int i = 0; i < N; i++) if (mW < 0 && getNum((mPtr + i) % N) != 0) mW = (mPtr + i) % N;
        if (mW >= 0) begin
          mPend = 1;
          eIdx = mW;
          eNum = getNum(mW);
          eAddr = getBase(mW) + {16'd0, getAddr(mW)};
        end
      end else if (mPend) begin
        if (bus.Gnt_Rdy) begin
          mPend = 0;
          mAct = 1;
          mPtr = (eIdx + 1) % N;
        end
      end else if (bus.Xfer_Done) mAct = 0;
    end
  end

  // every cycle: outputs must match the model whenever a grant exists
  always @(negedge clk) if (checking && rst_n) begin
    chk("vld", 32'(bus.Gnt_Vld), 32'(mPend));
    chk("busy", 32'(bus.Busy), 32'(mPend | mAct));
    if (mPend || mAct) begin
      chk("idx", 32'(bus.Gnt_Idx), eIdx);
      chk("rd", 32'(bus.Gnt_Rd), 32'(eIdx >= 4));
      chk("num", 32'(bus.Gnt_Num), 32'(eNum));
      chk("dramaddr", bus.Gnt_DramAddr, eAddr);
    end
  end

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitVld(input string name);
    int n = 0;
    while (!bus.Gnt_Vld && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_vld_wait"}, 32'(bus.Gnt_Vld), 32'd1);
  endtask

  task automatic grantDone();
    @(negedge clk);
    bus.Xfer_Done = 1'b1;
    @(negedge clk);
    bus.Xfer_Done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    logic [15:0] rn;
    clearReq();
    bus.Gnt_Rdy = 1'b0;
    bus.Xfer_Done = 1'b0;
    doReset();
    checking = 1'b1;
    chk("rst_vld", 32'(bus.Gnt_Vld), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_idx", 32'(bus.Gnt_Idx), 32'd0);
    chk("rst_num", 32'(bus.Gnt_Num), 32'd0);
    chk("rst_addr", bus.Gnt_DramAddr, 32'd0);
    // stray completion while idle must be ignored
    bus.Xfer_Done = 1'b1;
    @(negedge clk);
    bus.Xfer_Done = 1'b0;
    chk("idle_done_busy", 32'(bus.Busy), 32'd0);
    // single normal request: grant one cycle later
    setPort(3, 16'd8, 16'h0040, 32'h1000_0000);
    bus.Gnt_Rdy = 1'b1;
    @(negedge clk);
    chk("single_vld", 32'(bus.Gnt_Vld), 32'd1);
    chk("single_idx", 32'(bus.Gnt_Idx), 32'd3);
    chk("single_rd", 32'(bus.Gnt_Rd), 32'd0);
    chk("single_num", 32'(bus.Gnt_Num), 32'd8);
    chk("single_addr", bus.Gnt_DramAddr, 32'h1000_0040);
    clearReq();
    @(negedge clk);
    chk("xfer_vld", 32'(bus.Gnt_Vld), 32'd0);
    chk("xfer_busy", 32'(bus.Busy), 32'd1);
    bus.Xfer_Done = 1'b1;
    @(negedge clk);
    bus.Xfer_Done = 1'b0;
    chk("done_busy", 32'(bus.Busy), 32'd0);
    // urgent port 0 beats urgent port 2, which follows after completion
    bus.Req_Urgent[0] = 1'b1;
    bus.Req_Urgent[2] = 1'b1;
    @(negedge clk);
    chk("urg_first", 32'(bus.Gnt_Idx), 32'd0);
    chk("urg_first_num", 32'(bus.Gnt_Num), 32'd0);
    bus.Req_Urgent[0] = 1'b0;
    grantDone();
    waitVld("urg_second");
    chk("urg_second", 32'(bus.Gnt_Idx), 32'd2);
    clearReq();
    grantDone();
    // Gnt_Rdy low holds the command and payload
    bus.Gnt_Rdy = 1'b0;
    setPort(1, 16'd5, 16'h0007, 32'h0000_0100);
    @(negedge clk);
    chk("hold_vld0", 32'(bus.Gnt_Vld), 32'd1);
    clearReq();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_vld", 32'(bus.Gnt_Vld), 32'd1);
      chk("hold_idx", 32'(bus.Gnt_Idx), 32'd1);
      chk("hold_num", 32'(bus.Gnt_Num), 32'd5);
      chk("hold_addr", bus.Gnt_DramAddr, 32'h0000_0107);
    end
    bus.Gnt_Rdy = 1'b1;
    grantDone();
    // DRAM address wraps modulo 2^32
    setPort(5, 16'd1, 16'h0020, 32'hFFFF_FFF0);
    @(negedge clk);
    chk("wrap_idx", 32'(bus.Gnt_Idx), 32'd5);
    chk("wrap_rd", 32'(bus.Gnt_Rd), 32'd1);
    chk("wrap_addr", bus.Gnt_DramAddr, 32'h0000_0010);
    clearReq();
    grantDone();
    // all ports requesting: plain rotation from pointer 0
    doReset();
    for (int p = 0; p < N; p++) setPort(p, 16'd4, 16'd0, 32'd0);
    for (int k = 0; k < N; k++) begin
      waitVld("rr");
      chk("rr_idx", 32'(bus.Gnt_Idx), k);
      chk("rr_rd", 32'(bus.Gnt_Rd), 32'(k >= 4));
      grantDone();
    end
    clearReq();
    // reset during a transfer drops the grant at once
    setPort(2, 16'd3, 16'd0, 32'd0);
    waitVld("rst_xfer");
    clearReq();
    @(negedge clk);
    chk("rst_xfer_busy_before", 32'(bus.Busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_xfer_vld", 32'(bus.Gnt_Vld), 32'd0);
    chk("rst_xfer_busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
`ifdef ITF_SCHED_AGING_EN
    // a starving normal port is promoted despite a permanently urgent port
    bus.Req_Urgent[1] = 1'b1;
    setPort(5, 16'd2, 16'd0, 32'd0);
    found = 0;
    for (int g = 0; g < 4; g++) begin
      waitVld("age");
      if (bus.Gnt_Idx == 3'd5) found = 1;
      grantDone();
    end
    chk("age_port5", found, 32'd1);
    clearReq();
    doReset();
`endif
    // random traffic, including mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        rn = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        setPort(p, rn, 16'($urandom), ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255)) : $urandom);
        bus.Req_Urgent[p] = $urandom_range(0, 9) == 0;
      end
      bus.Gnt_Rdy = $urandom_range(0, 3) != 0;
      bus.Xfer_Done = $urandom_range(0, 2) == 0;
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    clearReq();
    bus.Xfer_Done = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
